// File: rtl/decode_pkg.sv
// Shared types and constants for the instruction-decode stage: opcode map,
// operation/ALU encodings and the decoded bundle carried to execute.
package decode_pkg;

  localparam int DADDR_MAX = 9;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_ORR   = 4'd4,
    OP_XOR   = 4'd5,
    OP_LSL   = 4'd6,
    OP_LOAD  = 4'd7,
    OP_STORE = 4'd8,
    OP_B     = 4'd9,
    OP_BR    = 4'd10,
    OP_BGT   = 4'd11
  } op_t;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_ORR  = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_LSL  = 3'd6
  } alu_t;

  localparam logic [10:0] OPC_STORE  = 11'h5C0;
  localparam logic [10:0] OPC_LOAD   = 11'h5C4;
  localparam logic [10:0] OPC_ADD    = 11'h458;
  localparam logic [10:0] OPC_SUB    = 11'h658;
  localparam logic [10:0] OPC_AND    = 11'h450;
  localparam logic [10:0] OPC_ORR    = 11'h550;
  localparam logic [10:0] OPC_XOR    = 11'h650;
  localparam logic [10:0] OPC_LSL    = 11'h69B;
  localparam logic [10:0] OPC_BR     = 11'h6B0;
  localparam logic [10:0] OPC_B_LO   = 11'h0A0;
  localparam logic [10:0] OPC_B_HI   = 11'h0BF;
  localparam logic [10:0] OPC_BGT_LO = 11'h2A0;
  localparam logic [10:0] OPC_BGT_HI = 11'h2A7;

  localparam logic [1:0] SRAM_WR   = 2'b00;
  localparam logic [1:0] SRAM_RD   = 2'b01;
  localparam logic [1:0] SRAM_IDLE = 2'b10;

  localparam logic [4:0] REG_NONE = 5'd31;

  typedef struct packed {
    op_t                  op;
    alu_t                 alu;
    logic                 reg_en;
    logic [1:0]           sram_rw;
    logic [4:0]           rn;
    logic [4:0]           rm;
    logic [4:0]           rd;
    logic [5:0]           shamt;
    logic [DADDR_MAX-1:0] addr;
    logic                 illegal;
  } decoded_t;

  localparam decoded_t NOP_BUNDLE = '{
    op:      OP_NOP,
    alu:     ALU_NONE,
    reg_en:  1'b0,
    sram_rw: SRAM_IDLE,
    rn:      REG_NONE,
    rm:      REG_NONE,
    rd:      REG_NONE,
    shamt:   6'd0,
    addr:    '0,
    illegal: 1'b0
  };

  function automatic logic reads_rn(op_t op);
    case (op)
      OP_STORE, OP_LOAD, OP_BR,
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR, OP_LSL: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rm(op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_XOR, OP_LSL: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_comb.sv
// Purely combinational opcode table: instruction word to decoded bundle.
// Unused register fields read 31 and unused address reads 0.
module decode_comb
  import decode_pkg::*;
#(
  parameter int DADDR_W = 9
) (
  input  logic [31:0] inst,
  output decoded_t    dec
);

  logic [10:0]          opc;
  logic [DADDR_MAX-1:0] addr;

  assign opc  = inst[31:21];
  assign addr = DADDR_MAX'(inst[12+DADDR_W-1:12]);

  always_comb begin
    dec         = NOP_BUNDLE;
    dec.illegal = 1'b0;
    if (opc == OPC_STORE) begin
      dec.op      = OP_STORE;
      dec.sram_rw = SRAM_WR;
      dec.rn      = inst[9:5];
      dec.addr    = addr;
    end else if (opc >= OPC_B_LO && opc <= OPC_B_HI) begin
      dec.op = OP_B;
    end else if (opc == OPC_BR) begin
      dec.op = OP_BR;
      dec.rn = inst[4:0];
    end else if (opc >= OPC_BGT_LO && opc <= OPC_BGT_HI) begin
      dec.op = OP_BGT;
    end else if (opc == OPC_LOAD) begin
      dec.op      = OP_LOAD;
      dec.reg_en  = 1'b1;
      dec.sram_rw = SRAM_RD;
      dec.rn      = inst[9:5];
      dec.rm      = inst[20:16];
      dec.rd      = inst[4:0];
      dec.addr    = addr;
    end else begin
      // Remaining legal opcodes are three-register ALU operations.
      dec.rn     = inst[9:5];
      dec.rm     = inst[20:16];
      dec.rd     = inst[4:0];
      dec.reg_en = 1'b1;
      case (opc)
        OPC_ADD: begin dec.op = OP_ADD; dec.alu = ALU_ADD; end
        OPC_SUB: begin dec.op = OP_SUB; dec.alu = ALU_SUB; end
        OPC_AND: begin dec.op = OP_AND; dec.alu = ALU_AND; end
        OPC_ORR: begin dec.op = OP_ORR; dec.alu = ALU_ORR; end
        OPC_XOR: begin dec.op = OP_XOR; dec.alu = ALU_XOR; end
        OPC_LSL: begin
          dec.op    = OP_LSL;
          dec.alu   = ALU_LSL;
          dec.shamt = inst[15:10];
        end
        default: begin
          dec         = NOP_BUNDLE;
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked decode stage between fetch and execute with
// load-use stalling, branch flush and illegal-opcode flagging.
module decode_stage
  import decode_pkg::*;
#(
  parameter int         DADDR_W      = 9,
  parameter int         LOAD_USE_GAP = 1,
  parameter logic [4:0] ZERO_REG     = 5'd31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         op,
  output logic [2:0]         alu_ctrl,
  output logic [DADDR_W-1:0] data_address,
  output logic               reg_en,
  output logic [1:0]         sram_rw,
  output logic [4:0]         rn,
  output logic [4:0]         rm,
  output logic [4:0]         rd,
  output logic [5:0]         shamt,
  output logic               illegal
);

  localparam int CNT_W = (LOAD_USE_GAP > 1) ? $clog2(LOAD_USE_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(LOAD_USE_GAP);

  decoded_t         dec_p0;
  decoded_t         bundle_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic [4:0]       ld_rd_p1;
  logic             hazard_cnt;
  logic             hazard_held;
  logic             hazard;
  logic             accept;
  logic             load_done;

  function automatic logic reads_reg(decoded_t d, logic [4:0] r);
    return (reads_rn(d.op) && d.rn == r) || (reads_rm(d.op) && d.rm == r);
  endfunction

  // Stage 0: decode the incoming word and check it against outstanding loads.
  decode_comb #(.DADDR_W(DADDR_W)) u_comb (
    .inst (inst),
    .dec  (dec_p0)
  );

  assign hazard_cnt  = (cnt_p1 != '0) && (ld_rd_p1 != ZERO_REG) &&
                       reads_reg(dec_p0, ld_rd_p1);
  // A load still sitting in the output register has not started its gap yet.
  assign hazard_held = (LOAD_USE_GAP != 0) && vld_p1 && (bundle_p1.op == OP_LOAD) &&
                       (bundle_p1.rd != ZERO_REG) && reads_reg(dec_p0, bundle_p1.rd);
  assign hazard      = hazard_cnt || hazard_held;

  assign in_ready  = (!vld_p1 || out_ready) && !hazard && !flush;
  assign accept    = in_valid && in_ready;
  assign load_done = vld_p1 && out_ready && (bundle_p1.op == OP_LOAD) &&
                     (bundle_p1.rd != ZERO_REG);

  // Stage 1: output register, handshake and load-use counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= NOP_BUNDLE;
      cnt_p1    <= '0;
      ld_rd_p1  <= ZERO_REG;
    end else if (flush) begin
      vld_p1 <= 1'b0;
      cnt_p1 <= '0;
    end else begin
      if (accept) begin
        vld_p1    <= 1'b1;
        bundle_p1 <= dec_p0;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (load_done) begin
        cnt_p1   <= GAP_LD;
        ld_rd_p1 <= bundle_p1.rd;
      end else if (cnt_p1 != '0) begin
        cnt_p1 <= cnt_p1 - 1'b1;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign op           = bundle_p1.op;
  assign alu_ctrl     = bundle_p1.alu;
  assign data_address = bundle_p1.addr[DADDR_W-1:0];
  assign reg_en       = bundle_p1.reg_en;
  assign sram_rw      = bundle_p1.sram_rw;
  assign rn           = bundle_p1.rn;
  assign rm           = bundle_p1.rm;
  assign rd           = bundle_p1.rd;
  assign shamt        = bundle_p1.shamt;
  assign illegal      = bundle_p1.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode table, load-use stall, back-pressure,
// flush and asynchronous reset.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [2:0]  alu_ctrl;
  logic [8:0]  data_address;
  logic        reg_en;
  logic [1:0]  sram_rw;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [4:0]  rd;
  logic [5:0]  shamt;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  // {op, alu_ctrl, reg_en, sram_rw, rn, rm, rd, illegal}
  logic [25:0] got;
  assign got = {op, alu_ctrl, reg_en, sram_rw, rn, rm, rd, illegal};

  localparam logic [25:0] E_NOP  = {4'd0, 3'd0, 1'b0, 2'b10, 5'd31, 5'd31, 5'd31, 1'b0};
  localparam logic [25:0] E_ADD  = {4'd1, 3'd1, 1'b1, 2'b10, 5'd1,  5'd2,  5'd3,  1'b0};
  localparam logic [25:0] E_ADD6 = {4'd1, 3'd1, 1'b1, 2'b10, 5'd5,  5'd2,  5'd6,  1'b0};
  localparam logic [25:0] E_LOAD = {4'd7, 3'd0, 1'b1, 2'b01, 5'd1,  5'd0,  5'd5,  1'b0};
  localparam logic [25:0] E_ILL  = {4'd0, 3'd0, 1'b0, 2'b10, 5'd31, 5'd31, 5'd31, 1'b1};
  localparam logic [25:0] E_STR  = {4'd8, 3'd0, 1'b0, 2'b00, 5'd1,  5'd31, 5'd31, 1'b0};
  localparam logic [25:0] E_LSL  = {4'd6, 3'd6, 1'b1, 2'b10, 5'd2,  5'd0,  5'd7,  1'b0};
  localparam logic [25:0] E_BR   = {4'd10, 3'd0, 1'b0, 2'b10, 5'd3, 5'd31, 5'd31, 1'b0};

  localparam logic [31:0] I_ADD  = 32'h8B020023;
  localparam logic [31:0] I_ADD6 = 32'h8B0200A6;
  localparam logic [31:0] I_LOAD = 32'hB8804025;

  decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inst         (inst),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .op           (op),
    .alu_ctrl     (alu_ctrl),
    .data_address (data_address),
    .reg_en       (reg_en),
    .sram_rw      (sram_rw),
    .rn           (rn),
    .rm           (rm),
    .rd           (rd),
    .shamt        (shamt),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; inst = '0; flush = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (got !== E_NOP) begin bad++; $display("FAIL reset_bundle got=%h want=%h", got, E_NOP); end
    total++; if (data_address !== 9'd0) begin bad++; $display("FAIL reset_addr got=%0d want=0", data_address); end
    total++; if (shamt !== 6'd0) begin bad++; $display("FAIL reset_shamt got=%0d want=0", shamt); end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    in_valid = 1'b1; inst = I_ADD; out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
    total++; if (got !== E_ADD) begin bad++; $display("FAIL add_bundle got=%h want=%h", got, E_ADD); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b want=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    int stall;
    in_valid = 1'b1; inst = I_LOAD; out_ready = 1'b1;
    @(posedge clk); #1;
    inst = I_ADD6;
    @(negedge clk);
    total++; if (got !== E_LOAD) begin bad++; $display("FAIL load_bundle got=%h want=%h", got, E_LOAD); end
    total++; if (data_address !== 9'd4) begin bad++; $display("FAIL load_addr got=%0d want=4", data_address); end
    stall = 0;
    while (in_ready !== 1'b1 && stall < 8) begin
      stall++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (stall !== 2) begin bad++; $display("FAIL load_use_stall got=%0d want=2", stall); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_ADD6 || out_valid !== 1'b1) begin bad++; $display("FAIL dep_add got=%h/%b want=%h/1", got, out_valid, E_ADD6); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL dep_add_dup got=%b want=0", out_valid); end
    @(posedge clk); #1;
    // Independent ADD right behind a LOAD must not stall.
    in_valid = 1'b1; inst = I_LOAD;
    @(posedge clk); #1;
    inst = I_ADD;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL indep_ready got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_ADD || out_valid !== 1'b1) begin bad++; $display("FAIL indep_add got=%h/%b want=%h/1", got, out_valid, E_ADD); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; inst = I_ADD; out_ready = 1'b0;
    @(posedge clk); #1;
    inst = I_ADD6;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (got !== E_ADD || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%h/%b want=%h/1", i, got, out_valid, E_ADD); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b want=0", i, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_ADD6 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_second got=%h/%b want=%h/1", got, out_valid, E_ADD6); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_dup got=%b want=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    in_valid = 1'b1; inst = I_LOAD; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1; inst = I_ADD;
    @(negedge clk);
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b/%b want=0/1", in_ready, out_valid); end
    @(posedge clk); #1;
    flush = 1'b0; inst = I_ADD6;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_counter got=%b want=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_ADD6 || out_valid !== 1'b1) begin bad++; $display("FAIL flush_next got=%h/%b want=%h/1", got, out_valid, E_ADD6); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_store();
    in_valid = 1'b1; out_ready = 1'b1; inst = 32'hFFFFFFFF;
    @(posedge clk); #1;
    inst = 32'hB8004020;
    @(negedge clk);
    total++; if (got !== E_ILL) begin bad++; $display("FAIL illegal got=%h want=%h", got, E_ILL); end
    total++; if (data_address !== 9'd0) begin bad++; $display("FAIL illegal_addr got=%0d want=0", data_address); end
    @(posedge clk); #1;
    inst = 32'hD3601447;
    @(negedge clk);
    total++; if (got !== E_STR) begin bad++; $display("FAIL store got=%h want=%h", got, E_STR); end
    total++; if (data_address !== 9'd4) begin bad++; $display("FAIL store_addr got=%0d want=4", data_address); end
    @(posedge clk); #1;
    inst = 32'hD6000003;
    @(negedge clk);
    total++; if (got !== E_LSL || shamt !== 6'd5) begin bad++; $display("FAIL lsl got=%h/%0d want=%h/5", got, shamt, E_LSL); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_BR || shamt !== 6'd0) begin bad++; $display("FAIL br got=%h/%0d want=%h/0", got, shamt, E_BR); end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; inst = I_ADD; out_ready = 1'b0;
    @(posedge clk); #1;
    inst = I_ADD6;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ar_stall got=%b want=0", in_ready); end
    @(posedge clk); #2;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", out_valid); end
    total++; if (got !== E_NOP || data_address !== 9'd0) begin bad++; $display("FAIL ar_bundle got=%h/%0d want=%h/0", got, data_address, E_NOP); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; inst = I_ADD6; out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL ar_first got=%b/%b want=0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    total++; if (got !== E_ADD6 || out_valid !== 1'b1) begin bad++; $display("FAIL ar_latency got=%h/%b want=%h/1", got, out_valid, E_ADD6); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_illegal_store();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode pipeline stage for the pipelined CPU. Sits between fetch (IF/ID) and execute (ID/EX).
- Decodes the 11-bit opcode field inst[31:21] into op, alu_ctrl, sram_rw, reg_en, register indices and data address.
- Adds what the flat combinational decoder lacks: a valid/ready output register, load-use hazard stalling, branch flush and illegal-opcode flagging.

Parameters:
- DADDR_W, 9, data address width; taken from inst[12+DADDR_W-1:12]; legal range 1..9.
- LOAD_USE_GAP, 1, cycles after a load issues during which a dependent instruction is refused; 0 disables hazard checking.
- ZERO_REG, 5'd31, register index that never creates a hazard.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- in_valid, input, 1, fetch presents inst.
- in_ready, output, 1, stage accepts inst this cycle.
- inst, input, 32, instruction word.
- flush, input, 1, branch taken; discard held and incoming instruction.
- out_valid, output, 1, decoded bundle valid.
- out_ready, input, 1, execute consumes bundle.
- op, output, 4, operation code.
- alu_ctrl, output, 3, ALU select.
- data_address, output, DADDR_W, SRAM address.
- reg_en, output, 1, register write enable.
- sram_rw, output, 2, 00 write, 01 read, 10 idle.
- rn / rm / rd, output, 5 each, register indices.
- shamt, output, 6, inst[15:10] for LSL, else 0.
- illegal, output, 1, unrecognised opcode.

Behaviour:
- Decode table (inst[31:21] → op, alu_ctrl, reg_en, sram_rw), first match wins:
  - 0x5C0 STORE → 1000, 000, 0, 00; rn = inst[9:5], addr valid.
  - 0x0A0..0x0BF B → 1001, 000, 0, 10.
  - 0x6B0 BR → 1010, 000, 0, 10; rn = inst[4:0].
  - 0x2A0..0x2A7 BGT → 1011, 000, 0, 10.
  - 0x5C4 LOAD → 0111, 000, 1, 01; rn = inst[9:5], rm = inst[20:16], rd = inst[4:0], addr valid.
  - ALU ops, all with rn = inst[9:5], rm = inst[20:16], rd = inst[4:0], reg_en = 1, sram_rw = 10: 0x458 ADD 0001/001; 0x658 SUB 0010/010; 0x450 AND 0011/011; 0x550 ORR 0100/100; 0x650 XOR 0101/101; 0x69B LSL 0110/110.
  - Anything else → NOP (0000, 000, 0, 10) with illegal = 1.
- Register fields an instruction does not use read 31. data_address is 0 when not used; never X.
- Reset: out_valid = 0, all bundle outputs = NOP values, rn/rm/rd = 31, illegal = 0, hazard counter = 0.
- Hazard condition: the hazard counter is non-zero, the candidate instruction reads the tracked load destination, and that destination ≠ ZERO_REG.
  - "Reads" means rn for STORE, LOAD, BR and ALU ops; rm for ALU ops only.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept (in_valid && in_ready): the decoded bundle is loaded into the output register and out_valid = 1 next cycle. Latency is exactly 1 cycle.
- Consume without accept: out_valid is cleared. The bundle is held stable while out_valid && !out_ready.
- Load tracking: when the bundle in the output register is a LOAD with rd ≠ ZERO_REG and out_valid && out_ready, capture that rd and load the counter with LOAD_USE_GAP. Otherwise the counter decrements toward 0 each cycle.
  - The hazard is checked against the captured rd and also against a LOAD currently held in the output register (not yet consumed).
- flush: synchronously clears out_valid and the counter. The incoming instruction is not accepted. flush overrides all simultaneous events.
- Stalling on a hazard never drops or duplicates an instruction. The fetch side must hold inst while in_ready = 0.
- Reset asserted mid-operation: returns immediately to reset values; no partial bundle survives.

Decomposition:
- Package decode_pkg:
  - op_t enum (NOP..BGT, 4 bits) and alu_t enum (3 bits).
  - Opcode constants OPC_STORE, OPC_LOAD, OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_XOR, OPC_LSL, OPC_BR; range bounds OPC_B_LO/HI and OPC_BGT_LO/HI.
  - SRAM_WR/RD/IDLE constants.
  - decoded_t struct for the bundle.
- Sub-module decode_comb: a purely combinational table (inst → decoded_t), also reused by the hazard check. decode_stage holds the registers, handshake and hazard counter.

Test Plan:
- Reset, then in_valid = 1 with inst 0x8B020023 (ADD X3,X1,X2), out_ready = 1 → next cycle out_valid = 1, op = 0001, alu_ctrl = 001, rn = 1, rm = 2, rd = 3, reg_en = 1, sram_rw = 10, illegal = 0.
- LOAD 0xB8804025 followed by ADD X6,X5,X2 (0x8B0200A6), out_ready = 1 → LOAD out with data_address = 4 and rd = 5. in_ready drops for exactly LOAD_USE_GAP + 1 cycles until the counter clears, then ADD issues with rn = 5. An independent ADD (0x8B020023) is never stalled.
- out_ready held 0 for 3 cycles with two back-to-back ADDs → first bundle stable, in_ready = 0, second accepted only on the cycle out_ready = 1. No loss or duplication.
- flush asserted while out_valid = 1 and in_valid = 1 → out_valid = 0 next cycle, input not accepted, hazard counter = 0.
- inst 0xFFFFFFFF → op = 0000, illegal = 1, reg_en = 0, sram_rw = 10, rn/rm/rd = 31. Next legal STORE 0xB8004020 → op = 1000, sram_rw = 00, rn = 1, data_address = 4, illegal = 0.
- rst pulsed low asynchronously mid-stall → outputs reach reset values without waiting for a clock edge. After release, the first accepted instruction appears after exactly 1 cycle.
